// File: rtl/mm_feeder.sv
// Read-DMA feeder for the mm engine: fetches len words from a synchronous-read
// memory, kicks mm once, streams the words through a 2-entry skid FIFO, then waits for mm_done.
module mm_feeder #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pLEN_WIDTH  = 10
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pADDR_WIDTH-1:0] base_addr,
    input  logic [pLEN_WIDTH-1:0]  len,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_en,
    output logic [pADDR_WIDTH-1:0] mem_addr,
    input  logic [pDATA_WIDTH-1:0] mem_rdata,
    output logic                   mm_start,
    input  logic                   mm_idle,
    input  logic                   mm_done,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_STREAM,
        S_WAIT_MM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [pADDR_WIDTH-1:0] base_q;
    logic [pLEN_WIDTH-1:0]  len_q;
    logic [pLEN_WIDTH-1:0]  rd_cnt;
    logic [pLEN_WIDTH-1:0]  beat_cnt;
    logic                   inflight;
    logic                   done_seen;
    logic                   load;
    logic                   pop;
    logic                   last_beat;
    logic [2:0]             occ;

    logic [pDATA_WIDTH-1:0] fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_cnt;

    assign m_tvalid  = (fifo_cnt != 2'd0);
    assign m_tdata   = fifo_mem[rd_ptr];
    assign pop       = m_tvalid & m_tready;
    assign last_beat = (beat_cnt == (len_q - pLEN_WIDTH'(1)));
    assign m_tlast   = m_tvalid & last_beat;
    assign mem_addr  = base_q + (pADDR_WIDTH'(rd_cnt) << 2);

    // Slots committed after this cycle: stored words plus the read landing next, minus the pop.
    assign occ = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mm_start  = 1'b0;
        mem_en    = 1'b0;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && mm_idle) begin
                    if (len == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = S_KICK;
                    end
                end
            end
            S_KICK: begin
                mm_start  = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                mem_en = (rd_cnt < len_q) && (occ < 3'd2);
                if (pop && last_beat) begin
                    state_nxt = S_WAIT_MM;
                end
            end
            S_WAIT_MM: begin
                if (done_seen || mm_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Job registers, counters and the early-mm_done latch
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            rd_cnt    <= '0;
            beat_cnt  <= '0;
            done_seen <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            inflight <= mem_en;
            if (load) begin
                base_q    <= base_addr & ~pADDR_WIDTH'(3);
                len_q     <= len;
                rd_cnt    <= '0;
                beat_cnt  <= '0;
                done_seen <= 1'b0;
            end else begin
                if (mem_en) begin
                    rd_cnt <= rd_cnt + pLEN_WIDTH'(1);
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + pLEN_WIDTH'(1);
                end
                if (mm_done && (state == S_KICK || state == S_STREAM || state == S_WAIT_MM)) begin
                    done_seen <= 1'b1;
                end
            end
        end
    end

    // Skid FIFO: read data lands the cycle after mem_en; issue rule guarantees a free slot
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= mem_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_mm_feeder.sv
// Scoreboard bench for mm_feeder: directed jobs push expected reads/beats,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mm_feeder;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 10;

    logic          axis_clk   = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          start      = 1'b0;
    logic [AW-1:0] base_addr  = '0;
    logic [LW-1:0] len        = '0;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata  = '0;
    logic          mm_start;
    logic          mm_idle    = 1'b1;
    logic          mm_done    = 1'b0;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready   = 1'b1;

    mm_feeder #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mm_start   (mm_start),
        .mm_idle    (mm_idle),
        .mm_done    (mm_done),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t       exp_q[$];
    logic [11:0] addr_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          ms_cnt = 0;
    int          ms_cyc = 0;
    int          rd_total = 0;
    int          issued = 0;
    int          popped = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] held = '0;
    logic        bp_mode = 1'b0;
    int          ph = 0;
    logic [3:0]  pat = 4'b1001;
    logic [31:0] mem [0:1023];
    beat_t       mon_b;
    logic [11:0] mon_a;

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Synchronous-read memory model
    always @(posedge axis_clk) if (mem_en) mem_rdata <= mem[mem_addr[11:2]];

    // Backpressure pattern driver: m_tready = 1,0,0,1 repeating
    always @(posedge axis_clk) begin
        #2;
        if (bp_mode) begin
            m_tready = pat[ph % 4];
            ph++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            issued     = 0;
            popped     = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(m_tvalid), 32'd1);
                chk("stall_data", m_tdata, held);
            end
            if (mem_en) begin
                rd_total++;
                issued++;
                if (addr_q.size() == 0) begin
                    flag("unexpected_read");
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(mon_a));
                end
            end
            if (m_tvalid && m_tready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    flag("unexpected_beat");
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("beat_data", m_tdata, mon_b.data);
                    chk("beat_last", 32'(m_tlast), 32'(mon_b.last));
                    if (mon_b.cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(mon_b.cyc));
                end
            end
            if (mem_en) chk("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
            stall_prev = m_tvalid && !m_tready;
            held       = m_tdata;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mm_start) begin
                ms_cnt++;
                ms_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge axis_clk);
        #2;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [9:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic expb(input logic [31:0] d, input logic last, input int rel);
        exp_q.push_back('{d, last, (rel < 0) ? -1 : start_cyc + rel});
    endtask

    task automatic wait_done(input int rel, input int budget);
        int c0;
        int k;
        c0 = done_cnt;
        k  = 0;
        while (done_cnt == c0 && k < budget) begin
            tick();
            k++;
        end
        if (done_cnt == c0) flag("done_timeout");
        else if (rel >= 0) chk("done_cycle", 32'(done_cyc - start_cyc), 32'(rel));
    endtask

    task automatic pulse_mm_done();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mm_start", 32'(mm_start), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    endtask

    task automatic chk_queues_empty();
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("reads_left", 32'(addr_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ms0;
        int rd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        repeat (3) tick();
        chk_reset_outputs();
        axis_rst_n = 1'b1;
        tick();

        // Basic stream: base 0x100, len 4, mm_done 10 cycles after mm_start
        for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0 + 32'(i);
        addr_q.push_back(12'h100); addr_q.push_back(12'h104);
        addr_q.push_back(12'h108); addr_q.push_back(12'h10C);
        ms0 = ms_cnt;
        do_start(12'h100, 10'd4);
        expb(32'hA0, 1'b0, 4); expb(32'hA1, 1'b0, 5);
        expb(32'hA2, 1'b0, 6); expb(32'hA3, 1'b1, 7);
        repeat (10) tick();
        pulse_mm_done();
        wait_done(12, 50);
        chk("t1_mm_start_count", 32'(ms_cnt - ms0), 32'd1);
        chk("t1_mm_start_cycle", 32'(ms_cyc - start_cyc), 32'd1);
        tick();
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk_queues_empty();

        // Backpressure: len 8, m_tready 1,0,0,1
        for (int i = 0; i < 8; i++) mem[32'h80 + i] = 32'hB0 + 32'(i);
        for (int i = 0; i < 8; i++) addr_q.push_back(12'h200 + 12'(4 * i));
        ph      = 0;
        bp_mode = 1'b1;
        do_start(12'h200, 10'd8);
        for (int i = 0; i < 8; i++) expb(32'hB0 + 32'(i), (i == 7), -1);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
        bp_mode = 1'b0;
        tick();
        m_tready = 1'b1;
        pulse_mm_done();
        wait_done(-1, 20);
        chk_queues_empty();

        // Empty job: done in cycle 1, no mm_start, no reads
        ms0 = ms_cnt;
        rd0 = rd_total;
        do_start(12'h300, 10'd0);
        wait_done(1, 5);
        chk("t3_len0_mm_start", 32'(ms_cnt - ms0), 32'd0);
        chk("t3_len0_reads", 32'(rd_total - rd0), 32'd0);

        // Blocked start while mm busy
        tick();
        mm_idle = 1'b0;
        do_start(12'h600, 10'd4);
        for (int k = 0; k < 3; k++) begin
            chk("t3_blocked_busy", 32'(busy), 32'd0);
            tick();
        end
        chk("t3_blocked_mm_start", 32'(ms_cnt - ms0), 32'd0);
        chk("t3_blocked_reads", 32'(rd_total - rd0), 32'd0);
        mm_idle = 1'b1;
        tick();

        // Early mm_done during STREAM plus address wrap
        mem[10'h3FE] = 32'hC0; mem[10'h3FF] = 32'hC1;
        mem[10'h000] = 32'hC2; mem[10'h001] = 32'hC3;
        addr_q.push_back(12'hFF8); addr_q.push_back(12'hFFC);
        addr_q.push_back(12'h000); addr_q.push_back(12'h004);
        do_start(12'hFF8, 10'd4);
        expb(32'hC0, 1'b0, 4); expb(32'hC1, 1'b0, 5);
        expb(32'hC2, 1'b0, 6); expb(32'hC3, 1'b1, 7);
        repeat (3) tick();
        pulse_mm_done();
        wait_done(9, 30);
        chk_queues_empty();
        tick();

        // Reset after two beats of a len-6 job
        for (int i = 0; i < 6; i++) mem[32'h100 + i] = 32'hD0 + 32'(i);
        for (int i = 0; i < 6; i++) addr_q.push_back(12'h400 + 12'(4 * i));
        do_start(12'h400, 10'd6);
        for (int i = 0; i < 6; i++) expb(32'hD0 + 32'(i), (i == 5), 4 + i);
        repeat (5) tick();
        chk("t5_beats_before_reset", 32'(exp_q.size()), 32'd4);
        axis_rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        addr_q.delete();
        tick();
        tick();
        axis_rst_n = 1'b1;
        tick();

        // Fresh len-3 job after reset
        for (int i = 0; i < 3; i++) mem[32'h140 + i] = 32'hE0 + 32'(i);
        addr_q.push_back(12'h500); addr_q.push_back(12'h504); addr_q.push_back(12'h508);
        do_start(12'h500, 10'd3);
        expb(32'hE0, 1'b0, 4); expb(32'hE1, 1'b0, 5); expb(32'hE2, 1'b1, 6);
        repeat (10) tick();
        pulse_mm_done();
        wait_done(12, 50);
        chk_queues_empty();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mm_feeder.md
# mm_feeder

Upstream read-DMA stage for the matrix-multiply engine `mm`. On a `start` pulse it reads `len` consecutive 32-bit words from a synchronous-read memory port and issues one `mm_start` pulse. It streams the words into `mm`'s AXI-Stream slave (`ss_*`) through a 2-entry skid FIFO, then waits for `mm_done` before reporting completion. It sits between the DMA/configuration logic and `mm`.

## Interface
Parameters:
- pADDR_WIDTH, 12, byte-address width of memory port
- pDATA_WIDTH, 32, stream/memory data width
- pLEN_WIDTH, 10, width of word-count input

Ports:
- axis_clk  in  1  clock, all logic on rising edge
- axis_rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; honoured only in IDLE with mm_idle=1, else ignored
- base_addr  in  pADDR_WIDTH  byte address of first word; bits [1:0] ignored; sampled with start
- len  in  pLEN_WIDTH  word count; sampled with start; 0 = empty job
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- mem_en  out  1  read strobe
- mem_addr  out  pADDR_WIDTH  read byte address; valid when mem_en=1
- mem_rdata  in  pDATA_WIDTH  read data, valid exactly one cycle after mem_en
- mm_start  out  1  one-cycle pulse to mm
- mm_idle  in  1  mm idle status
- mm_done  in  1  mm completion (pulse or level)
- m_tvalid  out  1  to mm ss_tvalid
- m_tdata  out  pDATA_WIDTH  to mm ss_tdata
- m_tlast  out  1  high on final beat
- m_tready  in  1  from mm ss_tready

## Operation
- States: IDLE, KICK, STREAM, WAIT_MM, DONE.
- IDLE: start=1, mm_idle=1, len≠0 → latch base_addr/len, clear counters and done_seen → KICK.
- IDLE: start=1, mm_idle=1, len=0 → DONE. No mm_start pulse and no memory reads.
- KICK: mm_start=1 for this cycle only → STREAM.
- STREAM read issue: mem_en=1 when rd_cnt<len and (fifo_cnt + inflight − pop) < 2.
  - inflight = mem_en of the previous cycle.
  - pop = m_tvalid & m_tready.
- Address: mem_addr = base_addr_aligned + 4·rd_cnt, modulo 2^pADDR_WIDTH (wraps silently).
- mem_rdata is written into the FIFO in the cycle after mem_en. The FIFO never overflows because of the issue rule.
- Stream output:
  - m_tvalid = FIFO non-empty; m_tdata = FIFO head.
  - m_tvalid/m_tdata stay stable while m_tready=0.
  - m_tlast = 1 when the head is word len−1.
- Last beat accepted (beat_cnt reaches len) → WAIT_MM.
- done_seen is set by mm_done in any cycle from KICK onward, so an early mm_done is not lost.
- WAIT_MM: done_seen or mm_done → DONE.
- DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- Reset, including mid-operation, forces IDLE and clears the FIFO, counters and done_seen. Any read in flight is discarded.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, mm_start=0, m_tvalid=0, m_tdata=0, m_tlast=0.
- Start accepted at edge of cycle 0:
  - cycle 1: KICK, mm_start=1.
  - cycle 2: first mem_en.
  - cycle 3: mem_rdata valid.
  - cycle 4: first m_tvalid=1.
- With m_tready held high: one beat per cycle, no bubbles. Last beat of a len-word job is in cycle len+3.
- WAIT_MM lasts at least one cycle. DONE follows the cycle after done_seen/mm_done is observed in WAIT_MM.
- len=0 job: DONE in cycle 1, done=1 in cycle 1.
- m_tready low: reads stop once FIFO plus in-flight reads reach 2. Reads resume in the same cycle a pop frees a slot.

## Test plan
- Basic stream: base 0x100, len 4, memory[i]=0xA0+i, m_tready=1, mm_done pulsed 10 cycles after mm_start.
  - Required: addresses 0x100/104/108/10C; beats 0xA0..0xA3 in cycles 4..7; m_tlast on 0xA3; done pulse after mm_done.
- Backpressure: len 8, m_tready toggles 1,0,0,1 repeating.
  - Required: data order preserved, no duplicate or dropped beats, at most 2 outstanding words, m_tdata stable while stalled.
- Empty and blocked starts:
  - len 0 → done in cycle 1, no mm_start, no mem_en.
  - start with mm_idle=0 → ignored, busy stays 0.
- Early mm_done and address wrap: base 0xFF8, len 4, mm_done pulsed during STREAM.
  - Required: addresses 0xFF8, 0xFFC, 0x000, 0x004; DONE reached one cycle after entering WAIT_MM.
- Reset mid-stream: assert axis_rst_n=0 after 2 beats of a len-6 job.
  - Required: all outputs reset immediately.
  - Then a fresh len-3 job streams correctly from its own base address.
